serial_add3_ctrl: RTL and testbench

SERIAL_ADD3_CTRL -- requirements
Module: serial_add3_ctrl

---
 rtl/serial_add3_ctrl_pkg.sv | 10 +
 rtl/serial_add3_ctrl_if.sv | 16 +
 rtl/full_adder.sv | 11 +
 rtl/serial_add3_ctrl.sv | 95 +++++++++
 tb/tb_serial_add3_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/serial_add3_ctrl_pkg.sv
// serial_add3_ctrl_pkg: shared FSM encoding and default operand width for the serial three-operand adder.
package serial_add3_ctrl_pkg;
   localparam int DEFAULT_WIDTH = 4;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/serial_add3_ctrl_if.sv
// serial_add3_ctrl_if: operand/result handshake bundle; master drives operands, slave is the adder.
interface serial_add3_ctrl_if import serial_add3_ctrl_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH+1:0] sum;
   logic             busy;
   modport master (output in_valid, a, b, c, out_ready, input in_ready, out_valid, sum, busy);
   modport slave  (input in_valid, a, b, c, out_ready, output in_ready, out_valid, sum, busy);
endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full-adder cell.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ c_i;
   assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_add3_ctrl.sv
// serial_add3_ctrl: a+b+c through one shared full adder, bit-serial in two passes
// (partial = a+b, then sum = partial + c).
module serial_add3_ctrl import serial_add3_ctrl_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic              clk,
   input logic              rst_n,
   serial_add3_ctrl_if.slave bus
);
   localparam int IW = $clog2(WIDTH + 1);
   state_t           state_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q, c_q;
   logic [WIDTH:0]   partial_q;
   logic [WIDTH+1:0] sum_q;
   logic             in_ready_q, out_valid_q, busy_q;
   logic [WIDTH:0]   a_ext, b_ext, c_ext;
   logic             fa_x, fa_y, fa_s, fa_co;
   assign a_ext = {1'b0, a_q};
   assign b_ext = {1'b0, b_q};
   assign c_ext = {1'b0, c_q};
   // The same cell serves both passes; only its operand taps change with state.
   assign fa_x = (state_q == PASS1) ? a_ext[idx_q] : partial_q[idx_q];
   assign fa_y = (state_q == PASS1) ? b_ext[idx_q] : c_ext[idx_q];
   full_adder u_fa (
      .a_i  (fa_x),
      .b_i  (fa_y),
      .c_i  (carry_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         partial_q   <= '0;
         sum_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               a_q        <= bus.a;
               b_q        <= bus.b;
               c_q        <= bus.c;
               idx_q      <= '0;
               carry_q    <= 1'b0;
               state_q    <= PASS1;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b1;
            end
            PASS1: begin
               partial_q[idx_q] <= fa_s;
               if (idx_q == IW'(WIDTH - 1)) begin
                  partial_q[WIDTH] <= fa_co;
                  carry_q          <= 1'b0;
                  idx_q            <= '0;
                  state_q          <= PASS2;
               end else begin
                  carry_q <= fa_co;
                  idx_q   <= idx_q + IW'(1);
               end
            end
            PASS2: begin
               sum_q[idx_q] <= fa_s;
               if (idx_q == IW'(WIDTH)) begin
                  sum_q[WIDTH+1] <= fa_co;
                  state_q        <= DONE;
                  out_valid_q    <= 1'b1;
               end else begin
                  carry_q <= fa_co;
                  idx_q   <= idx_q + IW'(1);
               end
            end
            DONE: if (bus.out_ready) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.sum       = sum_q;
endmodule

// File: tb/tb_serial_add3_ctrl.sv
// tb_serial_add3_ctrl: directed table, async-reset abort and exhaustive shuffled sweep
// of the serial adder against plain a+b+c with a fixed 9-edge latency.
module tb_serial_add3_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   serial_add3_ctrl_if #(.WIDTH(4)) bus ();
   serial_add3_ctrl #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
      int         hold;
      logic [5:0] exp;
   } vec_t;
   vec_t vecs[10];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // Called #1 after an edge (or mid-cycle); the operands are accepted on the next rising edge.
   task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] tc,
                        input int hold, input logic [5:0] exp, input string tag);
      int         lat;
      logic [5:0] s0;
      chk({tag, " in_ready before accept"}, 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.a = ta;
      bus.b = tb;
      bus.c = tc;
      @(posedge clk);
      #1;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         bus.in_valid = 1'b1;
         bus.a = 4'($urandom);
         bus.b = 4'($urandom);
         bus.c = 4'($urandom);
         chk({tag, " in_ready while busy"}, 32'(bus.in_ready), 0);
         chk({tag, " busy while busy"}, 32'(bus.busy), 1);
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) begin
            lat = k;
            break;
         end
      end
      bus.in_valid = 1'b0;
      chk({tag, " latency"}, 32'(lat), 9);
      chk({tag, " sum"}, 32'(bus.sum), 32'(exp));
      s0 = bus.sum;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk({tag, " out_valid held"}, 32'(bus.out_valid), 1);
         chk({tag, " sum held"}, 32'(bus.sum), 32'(s0));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, " in_ready after handshake"}, 32'(bus.in_ready), 1);
      chk({tag, " out_valid after handshake"}, 32'(bus.out_valid), 0);
      chk({tag, " busy after handshake"}, 32'(bus.busy), 0);
   endtask
   initial begin
      int         off;
      int         v;
      logic [3:0] ra, rb, rc;
      checks   = 0;
      failures = 0;
      vecs[0] = '{4'd0,  4'd0,  4'd0,  0, 6'd0};
      vecs[1] = '{4'd15, 4'd15, 4'd15, 0, 6'd45};
      vecs[2] = '{4'd5,  4'd10, 4'd3,  5, 6'd18};
      vecs[3] = '{4'd7,  4'd9,  4'd1,  1, 6'd17};
      vecs[4] = '{4'd1,  4'd2,  4'd4,  2, 6'd7};
      vecs[5] = '{4'd15, 4'd0,  4'd0,  0, 6'd15};
      vecs[6] = '{4'd0,  4'd15, 4'd0,  3, 6'd15};
      vecs[7] = '{4'd0,  4'd0,  4'd15, 0, 6'd15};
      vecs[8] = '{4'd8,  4'd8,  4'd8,  1, 6'd24};
      vecs[9] = '{4'd9,  4'd6,  4'd15, 0, 6'd30};
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.c = '0;
      #12;
      chk("reset in_ready", 32'(bus.in_ready), 1);
      chk("reset out_valid", 32'(bus.out_valid), 0);
      chk("reset busy", 32'(bus.busy), 0);
      chk("reset sum", 32'(bus.sum), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].hold, vecs[i].exp, $sformatf("vec%0d", i));
      // Abort mid-PASS2 with an asynchronous reset, then restart on the first edge after release.
      bus.in_valid = 1'b1;
      bus.a = 4'd7;
      bus.b = 4'd9;
      bus.c = 4'd1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async reset in_ready", 32'(bus.in_ready), 1);
      chk("async reset out_valid", 32'(bus.out_valid), 0);
      chk("async reset busy", 32'(bus.busy), 0);
      chk("async reset sum", 32'(bus.sum), 0);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         chk("out_valid during reset", 32'(bus.out_valid), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(4'd1, 4'd2, 4'd4, 0, 6'd7, "post-reset");
      // Every triple once, in a shuffled order, with random back-pressure.
      off = int'($urandom_range(0, 4095));
      for (int i = 0; i < 4096; i++) begin
         v  = (i * 2731 + off) % 4096;
         ra = 4'(v);
         rb = 4'(v >> 4);
         rc = 4'(v >> 8);
         do_op(ra, rb, rc, int'($urandom_range(0, 2)), 6'(ra) + 6'(rb) + 6'(rc), "sweep");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
